// File: rtl/block_256_to_byte.sv
// rtl/block_256_to_byte.sv - serialises a 256-bit block into bytes over a 4-phase ack handshake
module block_256_to_byte #(
   parameter int NBYTES = 32,
   parameter int CNT_W  = 5
) (
   input  logic                clk,
   input  logic                rst_p,
   input  logic                in_en,
   input  logic [8*NBYTES-1:0] block,
   input  logic                start,
   input  logic                ack1,
   output logic [7:0]          part_block,
   output logic                byte_rdy,
   output logic                busy,
   output logic                done,
   output logic                ovf
);
   localparam int BW = 8 * NBYTES;
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SHOW     = 2'd1;
   localparam logic [1:0] WAIT_LOW = 2'd2;
   localparam logic [1:0] FIN      = 2'd3;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

   logic             ack_s1_q, ack_s1_d;
   logic             ack_s2_q, ack_s2_d;
   logic             ack_d_q, ack_d_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [BW-1:0]    shadow_q, shadow_d;
   logic [7:0]       part_block_q, part_block_d;
   logic             byte_rdy_q, byte_rdy_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic             ack_rise, ack_low;

   always_comb begin
      ack_s1_d = ack_s1_q;
      ack_s2_d = ack_s2_q;
      ack_d_d  = ack_d_q;
      if (in_en) begin
         ack_s1_d = ack1;
         ack_s2_d = ack_s1_q;
         ack_d_d  = ack_s2_q;
      end
      ack_rise = ack_s2_q & ~ack_d_q;
      ack_low  = ~ack_s2_q;

      state_d      = state_q;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      part_block_d = part_block_q;
      byte_rdy_d   = byte_rdy_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      ovf_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               shadow_d     = block;
               part_block_d = block[BW-1 -: 8];
               idx_d        = '0;
               byte_rdy_d   = 1'b1;
               busy_d       = 1'b1;
               state_d      = SHOW;
            end
         end
         SHOW: begin
            // The next byte is loaded while byte_rdy drops, so it settles before rdy rises again.
            if (in_en && ack_rise) begin
               byte_rdy_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = FIN;
               end else begin
                  idx_d        = idx_q + CNT_W'(1);
                  part_block_d = shadow_q[BW-9 -: 8];
                  shadow_d     = shadow_q << 8;
                  state_d      = WAIT_LOW;
               end
            end
         end
         WAIT_LOW: begin
            if (in_en && ack_low) begin
               byte_rdy_d = 1'b1;
               state_d    = SHOW;
            end
         end
         FIN: begin
            if (in_en && ack_low) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A start outside IDLE (including the FIN->IDLE cycle) is dropped and flagged.
      if (start && (state_q != IDLE)) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_p) begin
         ack_s1_q     <= 1'b0;
         ack_s2_q     <= 1'b0;
         ack_d_q      <= 1'b0;
         state_q      <= IDLE;
         idx_q        <= '0;
         shadow_q     <= '0;
         part_block_q <= '0;
         byte_rdy_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         ack_s1_q     <= ack_s1_d;
         ack_s2_q     <= ack_s2_d;
         ack_d_q      <= ack_d_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         part_block_q <= part_block_d;
         byte_rdy_q   <= byte_rdy_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
      end
   end

   assign part_block = part_block_q;
   assign byte_rdy   = byte_rdy_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign ovf        = ovf_q;
endmodule

// File: tb/tb_block_256_to_byte.sv
// tb/tb_block_256_to_byte.sv - directed bench for block_256_to_byte with a Pi-side ack model
module tb_block_256_to_byte;
   logic         clk = 1'b0;
   logic         rst_p = 1'b1;
   logic         in_en = 1'b1;
   logic [255:0] block = '0;
   logic         start = 1'b0;
   logic         ack1 = 1'b0;
   logic [7:0]   part_block;
   logic         byte_rdy, busy, done, ovf;

   int n_checks = 0;
   int n_err = 0;
   int rise_cnt = 0;
   int done_cnt = 0;
   int ovf_cnt = 0;
   logic rdy_prev = 1'b0;

   block_256_to_byte dut (
      .clk(clk), .rst_p(rst_p), .in_en(in_en), .block(block), .start(start),
      .ack1(ack1), .part_block(part_block), .byte_rdy(byte_rdy), .busy(busy),
      .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (byte_rdy && !rdy_prev) rise_cnt++;
      rdy_prev = byte_rdy;
      if (done) done_cnt++;
      if (ovf) ovf_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [255:0] mk_block(input logic [7:0] base, input logic [7:0] step);
      logic [255:0] b;
      for (int i = 0; i < 32; i++) b[255-8*i -: 8] = base + step * 8'(i);
      return b;
   endfunction

   function automatic logic [7:0] exp_byte(input logic [255:0] b, input int i);
      return b[255-8*i -: 8];
   endfunction

   task automatic wait_rdy(input logic lvl, input string tag);
      int n = 0;
      while (byte_rdy !== lvl && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(byte_rdy), 64'(lvl));
   endtask

   task automatic pulse_start(input logic [255:0] b);
      block = b;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic run_bytes(input logic [255:0] b, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         wait_rdy(1'b1, "rdy_rise");
         check("byte", 64'(part_block), 64'(exp_byte(b, i)));
         ack1 = 1'b1;
         wait_rdy(1'b0, "rdy_fall");
         ack1 = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 64'(done), 64'(1));
   endtask

   initial begin
      logic [255:0] b1, b2;
      logic ok;

      // Reset
      tick(3);
      check("rst_part", 64'(part_block), 64'h0);
      check("rst_rdy", 64'(byte_rdy), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_ovf", 64'(ovf), 64'h0);
      rst_p = 1'b0;
      tick(2);
      check("idle_busy", 64'(busy), 64'h0);

      // T1 basic block 0x00..0x1F
      b1 = mk_block(8'h00, 8'h01);
      rise_cnt = 0; done_cnt = 0; ovf_cnt = 0;
      pulse_start(b1);
      check("t1_busy", 64'(busy), 64'h1);
      check("t1_rdy", 64'(byte_rdy), 64'h1);
      check("t1_first", 64'(part_block), 64'h00);
      run_bytes(b1, 0, 31);
      wait_done();
      tick(1);
      check("t1_done_pulse", 64'(done), 64'h0);
      check("t1_busy_end", 64'(busy), 64'h0);
      check("t1_last_hold", 64'(part_block), 64'h1F);
      tick(3);
      check("t1_rises", 64'(rise_cnt), 64'd32);
      check("t1_done_cnt", 64'(done_cnt), 64'd1);
      check("t1_ovf_cnt", 64'(ovf_cnt), 64'd0);

      // T2 ack held high for 50 clk after byte 0
      b1 = mk_block(8'hA0, 8'h01);
      rise_cnt = 0; done_cnt = 0;
      pulse_start(b1);
      wait_rdy(1'b1, "t2_rdy");
      check("t2_b0", 64'(part_block), 64'hA0);
      ack1 = 1'b1;
      wait_rdy(1'b0, "t2_fall");
      ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (byte_rdy !== 1'b0) ok = 1'b0;
      end
      check("t2_rdy_stays_low", 64'(ok), 64'h1);
      check("t2_next_loaded", 64'(part_block), 64'hA1);
      ack1 = 1'b0;
      tick(1);
      check("t2_still_low", 64'(byte_rdy), 64'h0);
      run_bytes(b1, 1, 31);
      wait_done();
      tick(3);
      check("t2_rises", 64'(rise_cnt), 64'd32);
      check("t2_done_cnt", 64'(done_cnt), 64'd1);

      // T3 second start during byte 5
      b1 = mk_block(8'h07, 8'h03);
      ovf_cnt = 0; done_cnt = 0;
      pulse_start(b1);
      run_bytes(b1, 0, 4);
      wait_rdy(1'b1, "t3_rdy5");
      pulse_start('1);
      check("t3_ovf", 64'(ovf), 64'h1);
      check("t3_busy", 64'(busy), 64'h1);
      tick(1);
      check("t3_ovf_pulse", 64'(ovf), 64'h0);
      check("t3_b5_kept", 64'(part_block), 64'(exp_byte(b1, 5)));
      run_bytes(b1, 5, 31);
      wait_done();
      tick(3);
      check("t3_ovf_cnt", 64'(ovf_cnt), 64'd1);
      check("t3_done_cnt", 64'(done_cnt), 64'd1);

      // T4 reset during byte 10, then a fresh block
      b1 = mk_block(8'h55, 8'h05);
      done_cnt = 0;
      pulse_start(b1);
      run_bytes(b1, 0, 9);
      wait_rdy(1'b1, "t4_rdy10");
      check("t4_b10", 64'(part_block), 64'(exp_byte(b1, 10)));
      rst_p = 1'b1;
      tick(1);
      rst_p = 1'b0;
      check("t4_part", 64'(part_block), 64'h0);
      check("t4_rdy", 64'(byte_rdy), 64'h0);
      check("t4_busy", 64'(busy), 64'h0);
      tick(5);
      check("t4_no_done", 64'(done_cnt), 64'd0);
      b2 = mk_block(8'h10, 8'h02);
      rise_cnt = 0;
      pulse_start(b2);
      check("t4_restart_b0", 64'(part_block), 64'h10);
      run_bytes(b2, 0, 31);
      wait_done();
      tick(3);
      check("t4_rises", 64'(rise_cnt), 64'd32);

      // T5 in_en low while ack toggles in SHOW
      b1 = mk_block(8'hC3, 8'h07);
      pulse_start(b1);
      run_bytes(b1, 0, 0);
      wait_rdy(1'b1, "t5_rdy1");
      in_en = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i % 3 == 0) ack1 = ~ack1;
         tick(1);
         if (byte_rdy !== 1'b1 || part_block !== exp_byte(b1, 1)) ok = 1'b0;
      end
      ack1 = 1'b0;
      tick(1);
      check("t5_frozen", 64'(ok), 64'h1);
      in_en = 1'b1;
      tick(4);
      check("t5_same_byte", 64'(part_block), 64'(exp_byte(b1, 1)));
      check("t5_rdy_held", 64'(byte_rdy), 64'h1);
      run_bytes(b1, 1, 31);
      wait_done();
      tick(2);

      // T6 back-to-back blocks, second start 1 clk after done
      b1 = mk_block(8'h01, 8'h09);
      b2 = mk_block(8'h80, 8'h0B);
      rise_cnt = 0; done_cnt = 0; ovf_cnt = 0;
      pulse_start(b1);
      run_bytes(b1, 0, 31);
      wait_done();
      pulse_start(b2);
      check("t6_busy2", 64'(busy), 64'h1);
      check("t6_b2_first", 64'(part_block), 64'h80);
      run_bytes(b2, 0, 31);
      wait_done();
      tick(3);
      check("t6_rises", 64'(rise_cnt), 64'd64);
      check("t6_done_cnt", 64'(done_cnt), 64'd2);
      check("t6_ovf_cnt", 64'(ovf_cnt), 64'd0);
      check("t6_busy_end", 64'(busy), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
